alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of register file entries, ALU operands and result.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream offers an instruction.
REQ-005 instr_ready  output  1  block accepts an instruction this cycle.
REQ-006 instr  input  9  [8:6] opcode, [5:4] dest, [3:2] src1, [1:0] src2.
REQ-007 load_en  input  1  external register-file write strobe.
REQ-008 load_addr  input  2  external write register index.
REQ-009 load_data  input  DATA_WIDTH  external write data.
REQ-010 alu_opcode  output  3  opcode driven to the downstream ALU.
REQ-011 alu_operand_1  output  DATA_WIDTH  first ALU operand, reg[src1].
REQ-012 alu_operand_2  output  DATA_WIDTH  second ALU operand, reg[src2].
REQ-013 alu_result  input  DATA_WIDTH  combinational ALU output returned to the block.
REQ-014 result_valid  output  1  one-cycle pulse: writeback completed.
REQ-015 result_data  output  DATA_WIDTH  value written at the last writeback.
REQ-016 result_dest  output  2  register index of the last writeback.
REQ-017 rd_addr  input  2  debug read index; rd_data  output  DATA_WIDTH  combinational reg[rd_addr].
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 Register file: 4 entries x DATA_WIDTH; opcode passed through unmodified (block is opcode-agnostic).
REQ-020 FSM states IDLE, EXECUTE, WRITEBACK; instr_ready = 1 only in IDLE.
REQ-021 IDLE: on instr_valid && instr_ready at edge N, register opcode, dest, reg[src1], reg[src2] into alu_opcode/alu_operand_1/alu_operand_2; go to EXECUTE.
REQ-022 EXECUTE (cycle after N): ALU outputs held stable; at edge N+1 write alu_result into reg[dest], capture result_data/result_dest; go to WRITEBACK.
REQ-023 WRITEBACK: result_valid = 1 for exactly this cycle; at edge N+2 go to IDLE; next accept possible at edge N+3 earliest.
REQ-024 alu_opcode/alu_operand_* hold last issued values in IDLE and WRITEBACK; change only on accept.
REQ-025 instr_valid without instr_ready is ignored; instr not sampled outside accept edge.
REQ-026 Operand read uses pre-edge register contents: load_en to src register on the accept edge is not bypassed (operand = old value).
REQ-027 load_en writes reg[load_addr] on any edge in any state.
REQ-028 load_en and ALU writeback to the same register on the same edge: ALU writeback wins; different registers: both written.
REQ-029 src1 == src2 and dest == src1/src2 are legal; dest overwritten only at writeback.
REQ-030 Result width truncated to DATA_WIDTH; no carry/flag storage.

Reset
REQ-031 reset asserted: state = IDLE, all 4 registers = 0, alu_opcode = 0, alu_operand_1/2 = 0, result_valid = 0, result_data = 0, result_dest = 0, busy = 0, immediately (asynchronous).
REQ-032 reset in EXECUTE or WRITEBACK aborts the instruction: no register write, no result_valid pulse.
REQ-033 After reset deasserts, instr_ready = 1 at the first clock cycle.

Verification
REQ-034 Reset then rd_addr 0..3 -> rd_data = 0 each; instr_ready = 1, busy = 0.
REQ-035 load r1=3, r2=1; issue opcode 000, dest 3, src1 1, src2 2; bench returns alu_result = 8'h04 -> operands 3/1 one cycle after accept, result_valid pulse 2 edges after accept with result_data 8'h04, result_dest 3, reg3 = 4.
REQ-036 Hold instr_valid high continuously with two instructions -> second accepted exactly 3 edges after first; instr_ready low in EXECUTE/WRITEBACK.
REQ-037 load_en to reg3 with 8'hAA on the same edge as writeback of 8'h55 to reg3 -> reg3 = 8'h55; repeat to reg0 -> reg0 = 8'hAA, reg3 = 8'h55.
REQ-038 load_en r1=8'h10 on accept edge of instruction with src1 1 (old r1 = 3) -> alu_operand_1 = 3, r1 = 8'h10 afterwards.
REQ-039 Assert reset during EXECUTE -> no result_valid, dest register unchanged (0), all outputs 0, instr_ready = 1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one register-file instruction at a time to an
// external combinational ALU and writes the returned result back.
// Each instruction takes three cycles: accept (IDLE), EXECUTE, WRITEBACK.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [8:0]            instr,
  input  logic                  load_en,
  input  logic [1:0]            load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand_1,
  output logic [DATA_WIDTH-1:0] alu_operand_2,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [1:0]            result_dest,
  input  logic [1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EXECUTE   = 2'd1,
    S_WRITEBACK = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [DATA_WIDTH-1:0] r_regs [4];
  logic [2:0]            r_opcode;
  logic [DATA_WIDTH-1:0] r_operand_1;
  logic [DATA_WIDTH-1:0] r_operand_2;
  logic [1:0]            r_dest;
  logic [DATA_WIDTH-1:0] r_result_data;
  logic [1:0]            r_result_dest;

  logic                  w_accept;
  logic                  w_wb_en;
  logic [2:0]            w_instr_opcode;
  logic [1:0]            w_instr_dest;
  logic [1:0]            w_instr_src1;
  logic [1:0]            w_instr_src2;

  assign w_instr_opcode = instr[8:6];
  assign w_instr_dest   = instr[5:4];
  assign w_instr_src1   = instr[3:2];
  assign w_instr_src2   = instr[1:0];

  assign instr_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_WRITEBACK);
  assign w_accept     = instr_valid && instr_ready;
  // The ALU result is committed on the edge that leaves EXECUTE.
  assign w_wb_en      = (r_state == S_EXECUTE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: fixed three-cycle sequence per accepted instruction.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_next = S_EXECUTE;
      S_EXECUTE:   w_state_next = S_WRITEBACK;
      S_WRITEBACK: w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Register file: external load and ALU writeback; writeback wins on a clash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wb_en && (r_dest == 2'(i))) begin
          r_regs[i] <= alu_result;
        end else if (load_en && (load_addr == 2'(i))) begin
          r_regs[i] <= load_data;
        end
      end
    end
  end

  // Issue registers: capture opcode and pre-edge operand values on accept only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opcode    <= '0;
      r_operand_1 <= '0;
      r_operand_2 <= '0;
      r_dest      <= '0;
    end else if (w_accept) begin
      r_opcode    <= w_instr_opcode;
      r_operand_1 <= r_regs[w_instr_src1];
      r_operand_2 <= r_regs[w_instr_src2];
      r_dest      <= w_instr_dest;
    end
  end

  // Result registers: remember the value and index of the last writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result_data <= '0;
      r_result_dest <= '0;
    end else if (w_wb_en) begin
      r_result_data <= alu_result;
      r_result_dest <= r_dest;
    end
  end

  assign alu_opcode    = r_opcode;
  assign alu_operand_1 = r_operand_1;
  assign alu_operand_2 = r_operand_2;
  assign result_data   = r_result_data;
  assign result_dest   = r_result_dest;
  assign rd_data       = r_regs[rd_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed stimulus with a scoreboard queue of
// expected writebacks, checked by an independent monitor on result_valid.
module tb_alu_issue_ctrl;

  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [8:0]    instr;
  logic          load_en;
  logic [1:0]    load_addr;
  logic [DW-1:0] load_data;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_operand_1;
  logic [DW-1:0] alu_operand_2;
  logic [DW-1:0] alu_result;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic [1:0]    result_dest;
  logic [1:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;

  typedef struct packed {
    logic [1:0]    dest;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  alu_issue_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .alu_opcode    (alu_opcode),
    .alu_operand_1 (alu_operand_1),
    .alu_operand_2 (alu_operand_2),
    .alu_result    (alu_result),
    .result_valid  (result_valid),
    .result_data   (result_data),
    .result_dest   (result_dest),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple downstream ALU.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_operand_1 + alu_operand_2;
      3'b001:  alu_result = alu_operand_1 - alu_operand_2;
      3'b010:  alu_result = alu_operand_1 & alu_operand_2;
      3'b011:  alu_result = alu_operand_1 | alu_operand_2;
      default: alu_result = alu_operand_1 ^ alu_operand_2;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [DW-1:0] exp);
    rd_addr = a;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] d,
                                    input logic [1:0] s1, input logic [1:0] s2);
    return {op, d, s1, s2};
  endfunction

  // Monitor: every result_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mon_result_data", 32'(result_data), 32'(e.data));
        check("mon_result_dest", 32'(result_dest), 32'(e.dest));
      end
    end
  end

  task automatic load(input logic [1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr = '0; load_en = 1'b0;
    load_addr = '0; load_data = '0; rd_addr = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    tick(); tick();
    reset = 1'b0;
    // Reset state
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_op1", 32'(alu_operand_1), 32'd0);
    check("rst_result_data", 32'(result_data), 32'd0);
    for (int i = 0; i < 4; i++) rd_check("rst_reg", 2'(i), 8'h00);

    // Basic issue: r3 = r1 + r2 = 3 + 1
    load(2'd1, 8'h03);
    load(2'd2, 8'h01);
    instr = mk(3'b000, 2'd3, 2'd1, 2'd2); instr_valid = 1'b1;
    sb_q.push_back('{dest: 2'd3, data: 8'h04});
    tick();                        // edge N
    instr_valid = 1'b0; instr = '1;
    check("ex_ready", 32'(instr_ready), 32'd0);
    check("ex_busy", 32'(busy), 32'd1);
    check("ex_opcode", 32'(alu_opcode), 32'd0);
    check("ex_op1", 32'(alu_operand_1), 32'h03);
    check("ex_op2", 32'(alu_operand_2), 32'h01);
    check("ex_no_valid", 32'(result_valid), 32'd0);
    tick();                        // edge N+1
    check("wb_valid", 32'(result_valid), 32'd1);
    check("wb_ready", 32'(instr_ready), 32'd0);
    check("wb_data", 32'(result_data), 32'h04);
    tick();                        // edge N+2
    check("idle_valid", 32'(result_valid), 32'd0);
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("idle_op1_hold", 32'(alu_operand_1), 32'h03);
    rd_check("reg3_after_add", 2'd3, 8'h04);

    // Back-to-back with instr_valid held high: r0 = r3 - r1 = 1, then r2 = r3 | r0 = 5
    instr = mk(3'b001, 2'd0, 2'd3, 2'd1); instr_valid = 1'b1;
    sb_q.push_back('{dest: 2'd0, data: 8'h01});
    tick();                        // accept A
    instr = mk(3'b011, 2'd2, 2'd3, 2'd0);
    sb_q.push_back('{dest: 2'd2, data: 8'h05});
    tick();
    check("b2b_ready_exec", 32'(instr_ready), 32'd0);
    tick();
    check("b2b_ready_idle", 32'(instr_ready), 32'd1);
    check("b2b_opcode_not_yet", 32'(alu_opcode), 32'b001);
    tick();                        // accept B, 3 edges after A
    instr_valid = 1'b0;
    check("b2b_ready_busy", 32'(instr_ready), 32'd0);
    check("b2b_opcode_B", 32'(alu_opcode), 32'b011);
    check("b2b_op2_B", 32'(alu_operand_2), 32'h01);
    tick(); tick();
    rd_check("b2b_reg0", 2'd0, 8'h01);
    rd_check("b2b_reg2", 2'd2, 8'h05);

    // Load/writeback clash on reg3: writeback of 0x55 wins over load of 0xAA
    load(2'd1, 8'h50);
    load(2'd2, 8'h05);
    instr = mk(3'b000, 2'd3, 2'd1, 2'd2); instr_valid = 1'b1;
    sb_q.push_back('{dest: 2'd3, data: 8'h55});
    tick();
    instr_valid = 1'b0;
    load_en = 1'b1; load_addr = 2'd3; load_data = 8'hAA;
    tick();                        // writeback edge
    load_en = 1'b0;
    tick();
    rd_check("clash_reg3", 2'd3, 8'h55);
    // Same again but load targets reg0: both writes land
    instr = mk(3'b000, 2'd3, 2'd1, 2'd2); instr_valid = 1'b1;
    sb_q.push_back('{dest: 2'd3, data: 8'h55});
    tick();
    instr_valid = 1'b0;
    load_en = 1'b1; load_addr = 2'd0; load_data = 8'hAA;
    tick();
    load_en = 1'b0;
    tick();
    rd_check("split_reg0", 2'd0, 8'hAA);
    rd_check("split_reg3", 2'd3, 8'h55);

    // Load to src1 on accept edge is not bypassed
    load(2'd1, 8'h03);
    instr = mk(3'b000, 2'd2, 2'd1, 2'd2); instr_valid = 1'b1;
    load_en = 1'b1; load_addr = 2'd1; load_data = 8'h10;
    sb_q.push_back('{dest: 2'd2, data: 8'h08});
    tick();
    instr_valid = 1'b0; load_en = 1'b0;
    check("nobypass_op1", 32'(alu_operand_1), 32'h03);
    tick(); tick();
    rd_check("nobypass_reg1", 2'd1, 8'h10);
    rd_check("nobypass_reg2", 2'd2, 8'h08);

    // Reset during EXECUTE aborts the instruction
    instr = mk(3'b100, 2'd0, 2'd1, 2'd2); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("abort_in_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_opcode", 32'(alu_opcode), 32'd0);
    check("abort_op1", 32'(alu_operand_1), 32'd0);
    check("abort_op2", 32'(alu_operand_2), 32'd0);
    check("abort_rdata", 32'(result_data), 32'd0);
    check("abort_rdest", 32'(result_dest), 32'd0);
    tick();
    reset = 1'b0;
    check("abort_ready", 32'(instr_ready), 32'd1);
    tick(); tick(); tick();
    check("abort_ready_later", 32'(instr_ready), 32'd1);
    rd_check("abort_reg0", 2'd0, 8'h00);
    rd_check("abort_reg1", 2'd1, 8'h00);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
